scan_direction: RTL and testbench

SCAN_DIRECTION -- requirements
Module: scan_direction

---
 rtl/elevator_pkg.sv | 42 ++++
 rtl/floor_scan.sv | 40 ++++
 rtl/scan_direction.sv | 132 +++++++++++++
 tb/tb_scan_direction.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/elevator_pkg.sv
// Shared direction encodings, scan FSM state type and the direction-preference rule table.
package elevator_pkg;

   localparam logic [1:0] DIR_UP   = 2'b10;
   localparam logic [1:0] DIR_DOWN = 2'b01;
   localparam logic [1:0] DIR_NONE = 2'b00;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_UP    = 2'd1,
      ST_DOWN  = 2'd2,
      ST_DWELL = 2'd3
   } state_t;

   // A DOWN rule set prefers below over above; IDLE and UP prefer above.
   function automatic state_t scan_next(input state_t rule, input logic here,
                                        input logic above, input logic below);
      state_t nxt;
      nxt = ST_IDLE;
      if (here) begin
         nxt = ST_DWELL;
      end else if (rule == ST_DOWN) begin
         if (below)      nxt = ST_DOWN;
         else if (above) nxt = ST_UP;
      end else begin
         if (above)      nxt = ST_UP;
         else if (below) nxt = ST_DOWN;
      end
      return nxt;
   endfunction

   function automatic logic [1:0] dir_of(input state_t s);
      logic [1:0] d;
      case (s)
         ST_UP:   d = DIR_UP;
         ST_DOWN: d = DIR_DOWN;
         default: d = DIR_NONE;
      endcase
      return d;
   endfunction

endpackage

// File: rtl/floor_scan.sv
// Combinational request scan around the car: hit at, above and below the current floor.
// All flags forced low when the car position is not exactly one-hot; no state, no backpressure.
module floor_scan #(
   parameter int NUM_FLOORS = 6
) (
   input  logic [NUM_FLOORS-1:0] i_current_floor,
   input  logic [NUM_FLOORS-1:0] i_pending,
   output logic                  o_here,
   output logic                  o_above,
   output logic                  o_below,
   output logic                  o_valid
);

   logic w_above_raw;
   logic w_below_raw;
   logic w_seen_lo;
   logic w_seen_hi;

   // A pending bit counts as above once the car bit has been passed walking upward.
   always_comb begin
      w_above_raw = 1'b0;
      w_seen_lo   = 1'b0;
      for (int i = 0; i < NUM_FLOORS; i++) begin
         w_above_raw = w_above_raw | (i_pending[i] & w_seen_lo);
         w_seen_lo   = w_seen_lo | i_current_floor[i];
      end
      w_below_raw = 1'b0;
      w_seen_hi   = 1'b0;
      for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
         w_below_raw = w_below_raw | (i_pending[i] & w_seen_hi);
         w_seen_hi   = w_seen_hi | i_current_floor[i];
      end
   end

   assign o_valid = ($countones(i_current_floor) == 1);
   assign o_here  = o_valid & (|(i_pending & i_current_floor));
   assign o_above = o_valid & w_above_raw;
   assign o_below = o_valid & w_below_raw;

endmodule

// File: rtl/scan_direction.sv
// SCAN elevator direction controller; direction follows pending with one cycle latency, no backpressure.
// Define SCAN_DWELL_EN to add the timed door-open DWELL stop; otherwise floors are serviced on the fly.
module scan_direction
   import elevator_pkg::*;
#(
   parameter int NUM_FLOORS   = 6,
   parameter int DWELL_CYCLES = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [NUM_FLOORS-1:0] currentFloor,
   input  logic [NUM_FLOORS-1:0] reqSet,
   output logic [1:0]            direction,
   output logic [NUM_FLOORS-1:0] pending,
   output logic [NUM_FLOORS-1:0] served,
   output logic                  doorOpen
);

   if (NUM_FLOORS < 2 || DWELL_CYCLES < 1) begin : g_bad_param
      $error("scan_direction: NUM_FLOORS must be >= 2 and DWELL_CYCLES >= 1");
   end

   state_t                  r_state;
   logic [NUM_FLOORS-1:0]   r_pending;
   logic [NUM_FLOORS-1:0]   r_served;
   logic                    w_here;
   logic                    w_above;
   logic                    w_below;
   logic                    w_valid;
   logic [NUM_FLOORS-1:0]   w_set;
   logic [NUM_FLOORS-1:0]   w_set_clr;
   state_t                  w_scan_next;

   floor_scan #(
      .NUM_FLOORS(NUM_FLOORS)
   ) u_floor_scan (
      .i_current_floor(currentFloor),
      .i_pending      (r_pending),
      .o_here         (w_here),
      .o_above        (w_above),
      .o_below        (w_below),
      .o_valid        (w_valid)
   );

   assign w_set     = r_pending | reqSet;
   // Clear beats a same-cycle call at the floor being serviced.
   assign w_set_clr = w_set & ~currentFloor;

`ifdef SCAN_DWELL_EN

   localparam int              CW     = $clog2(DWELL_CYCLES + 1);
   localparam logic [CW-1:0]   RELOAD = CW'(DWELL_CYCLES - 1);

   state_t          r_last_dir;
   logic [CW-1:0]   r_cnt;
   state_t          w_rule;
   logic            w_hit;

   // On dwell expiry the travel direction held before the stop picks the rule set.
   assign w_rule      = (r_state == ST_DWELL) ? r_last_dir : r_state;
   assign w_scan_next = scan_next(w_rule, w_here, w_above, w_below);
   assign w_hit       = (r_state == ST_DWELL) && w_valid && (|(reqSet & currentFloor));

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= ST_IDLE;
         r_last_dir <= ST_IDLE;
         r_cnt      <= '0;
         r_pending  <= '0;
         r_served   <= '0;
      end else begin
         r_served  <= '0;
         r_pending <= w_set;
         if (!w_valid) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
         end else if (w_hit) begin
            r_cnt     <= RELOAD;
            r_served  <= currentFloor;
            r_pending <= w_set_clr;
         end else if (r_state == ST_DWELL && r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
         end else begin
            r_state <= w_scan_next;
            if (w_scan_next == ST_DWELL) begin
               r_cnt     <= RELOAD;
               r_served  <= currentFloor;
               r_pending <= w_set_clr;
               if (r_state != ST_DWELL) begin
                  r_last_dir <= r_state;
               end
            end
         end
      end
   end

   assign doorOpen = (r_state == ST_DWELL);

`else

   // The stop is folded into the travel cycle, so the rules run as if nothing were here.
   assign w_scan_next = scan_next(r_state, 1'b0, w_above, w_below);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= ST_IDLE;
         r_pending <= '0;
         r_served  <= '0;
      end else begin
         r_served  <= '0;
         r_pending <= w_set;
         if (!w_valid) begin
            r_state <= ST_IDLE;
         end else begin
            r_state <= w_scan_next;
            if (w_here) begin
               r_served  <= currentFloor;
               r_pending <= w_set_clr;
            end
         end
      end
   end

   assign doorOpen = 1'b0;

`endif

   assign direction = dir_of(r_state);
   assign pending   = r_pending;
   assign served    = r_served;

endmodule

// File: tb/tb_scan_direction.sv
// Scoreboarded bench for scan_direction; served pulses and state probes are checked by one monitor.
module tb_scan_direction;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [5:0] currentFloor = 6'b000001;
   logic [5:0] reqSet = 6'b000000;
   logic [1:0] direction;
   logic [5:0] pending;
   logic [5:0] served;
   logic       doorOpen;

   scan_direction #(
      .NUM_FLOORS  (6),
      .DWELL_CYCLES(4)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .currentFloor(currentFloor),
      .reqSet      (reqSet),
      .direction   (direction),
      .pending     (pending),
      .served      (served),
      .doorOpen    (doorOpen)
   );

   always #5 clk = ~clk;

   typedef struct {
      string      name;
      int         sel;
      logic [7:0] val;
   } chk_t;

   localparam int SEL_PEND = 0;
   localparam int SEL_DIR  = 1;
   localparam int SEL_DOOR = 2;
   localparam int SEL_SERV = 3;
   localparam int SEL_SBQ  = 4;

   logic [5:0] sb[$];
   chk_t       cq[$];
   int         total = 0;
   int         bad = 0;
   logic [5:0] mon_exp;
   logic [7:0] mon_act;
   chk_t       mon_c;

   always @(negedge clk) begin
      if (served != 6'b0) begin
         total++;
         if (sb.size() == 0) begin
            bad++;
            $display("FAIL served_unexpected got=%b want=none", served);
         end else begin
            mon_exp = sb.pop_front();
            if (served !== mon_exp) begin
               bad++;
               $display("FAIL served_pulse got=%b want=%b", served, mon_exp);
            end
         end
      end
      while (cq.size() > 0) begin
         mon_c = cq.pop_front();
         case (mon_c.sel)
            SEL_PEND: mon_act = {2'b00, pending};
            SEL_DIR:  mon_act = {6'b0, direction};
            SEL_DOOR: mon_act = {7'b0, doorOpen};
            SEL_SERV: mon_act = {2'b00, served};
            default:  mon_act = 8'(sb.size());
         endcase
         total++;
         if (mon_act !== mon_c.val) begin
            bad++;
            $display("FAIL %s got=%b want=%b", mon_c.name, mon_act, mon_c.val);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic ex(input string name, input int sel, input logic [7:0] val);
      chk_t c;
      c.name = name;
      c.sel  = sel;
      c.val  = val;
      cq.push_back(c);
   endtask

   initial begin
      tick();
      tick();
      reset = 1'b0;
      ex("rst_pending", SEL_PEND, 8'b0);
      ex("rst_dir", SEL_DIR, 8'b0);
      ex("rst_door", SEL_DOOR, 8'b0);
      ex("rst_served", SEL_SERV, 8'b0);

`ifdef SCAN_DWELL_EN
      // Call from the top floor, travel up, timed stop, back to idle.
      reqSet = 6'b100000;
      tick();
      reqSet = 6'b000000;
      ex("call_pending", SEL_PEND, 8'b00100000);
      ex("call_dir_lat", SEL_DIR, 8'b00);
      tick();
      ex("call_dir_up", SEL_DIR, 8'b10);
      sb.push_back(6'b100000);
      currentFloor = 6'b100000;
      tick();
      ex("arrive_door", SEL_DOOR, 8'd1);
      ex("arrive_pending", SEL_PEND, 8'b0);
      ex("arrive_dir", SEL_DIR, 8'b00);
      repeat (3) begin
         tick();
         ex("dwell_door", SEL_DOOR, 8'd1);
      end
      tick();
      ex("dwell_end_door", SEL_DOOR, 8'd0);
      ex("dwell_end_dir", SEL_DIR, 8'b00);

      // Up preference held mid-shaft, then reversal after the top stop.
      currentFloor = 6'b000100;
      reqSet = 6'b100001;
      tick();
      reqSet = 6'b000000;
      ex("two_pending", SEL_PEND, 8'b00100001);
      ex("two_dir_lat", SEL_DIR, 8'b00);
      tick();
      ex("two_dir_up", SEL_DIR, 8'b10);
      tick();
      ex("two_up_held", SEL_DIR, 8'b10);
      currentFloor = 6'b001000;
      tick();
      ex("two_up_f3", SEL_DIR, 8'b10);
      sb.push_back(6'b100000);
      currentFloor = 6'b100000;
      tick();
      ex("top_door", SEL_DOOR, 8'd1);
      ex("top_pending", SEL_PEND, 8'b00000001);
      repeat (3) tick();
      tick();
      ex("rev_dir_down", SEL_DIR, 8'b01);
      ex("rev_door", SEL_DOOR, 8'd0);
      sb.push_back(6'b000001);
      currentFloor = 6'b000001;
      tick();
      ex("bot_door", SEL_DOOR, 8'd1);
      ex("bot_pending", SEL_PEND, 8'b0);
      repeat (3) tick();
      tick();
      ex("bot_idle_dir", SEL_DIR, 8'b00);

      // Call at the open door on the third dwell cycle restarts the stop.
      currentFloor = 6'b000100;
      reqSet = 6'b000100;
      tick();
      reqSet = 6'b000000;
      ex("here_pending", SEL_PEND, 8'b00000100);
      sb.push_back(6'b000100);
      tick();
      ex("here_door", SEL_DOOR, 8'd1);
      ex("here_cleared", SEL_PEND, 8'b0);
      tick();
      tick();
      reqSet = 6'b000100;
      sb.push_back(6'b000100);
      tick();
      reqSet = 6'b000000;
      ex("reload_pending", SEL_PEND, 8'b0);
      ex("reload_door", SEL_DOOR, 8'd1);
      repeat (3) begin
         tick();
         ex("reload_door_hold", SEL_DOOR, 8'd1);
      end
      tick();
      ex("reload_door_end", SEL_DOOR, 8'd0);
`else
      // Call at the idle car's own floor is serviced without opening the door.
      currentFloor = 6'b000010;
      reqSet = 6'b000010;
      tick();
      reqSet = 6'b000000;
      ex("nd_pending", SEL_PEND, 8'b00000010);
      ex("nd_door", SEL_DOOR, 8'd0);
      sb.push_back(6'b000010);
      tick();
      ex("nd_cleared", SEL_PEND, 8'b0);
      ex("nd_dir", SEL_DIR, 8'b00);
      ex("nd_door2", SEL_DOOR, 8'd0);

      currentFloor = 6'b000001;
      reqSet = 6'b100000;
      tick();
      reqSet = 6'b000000;
      ex("nd_call_pending", SEL_PEND, 8'b00100000);
      tick();
      ex("nd_call_up", SEL_DIR, 8'b10);
      sb.push_back(6'b100000);
      currentFloor = 6'b100000;
      tick();
      ex("nd_top_dir", SEL_DIR, 8'b00);
      ex("nd_top_pending", SEL_PEND, 8'b0);
      ex("nd_top_door", SEL_DOOR, 8'd0);

      currentFloor = 6'b000100;
      reqSet = 6'b100001;
      tick();
      reqSet = 6'b000000;
      tick();
      ex("nd_two_up", SEL_DIR, 8'b10);
      sb.push_back(6'b100000);
      currentFloor = 6'b100000;
      tick();
      ex("nd_rev_down", SEL_DIR, 8'b01);
      ex("nd_rev_pending", SEL_PEND, 8'b00000001);
      sb.push_back(6'b000001);
      currentFloor = 6'b000001;
      tick();
      ex("nd_bot_dir", SEL_DIR, 8'b00);
      ex("nd_bot_pending", SEL_PEND, 8'b0);
`endif

      // Non-one-hot position parks the car but keeps collecting calls.
      currentFloor = 6'b000110;
      reqSet = 6'b100000;
      tick();
      reqSet = 6'b000000;
      tick();
      ex("inv_dir", SEL_DIR, 8'b00);
      ex("inv_pending", SEL_PEND, 8'b00100000);
      currentFloor = 6'b000010;
      tick();
      ex("inv_restore_up", SEL_DIR, 8'b10);

      // Reset during travel drops every request, including one raised in the reset cycle.
      reqSet = 6'b001000;
      tick();
      reqSet = 6'b000000;
      ex("trav_pending", SEL_PEND, 8'b00101000);
      ex("trav_dir", SEL_DIR, 8'b10);
      reset = 1'b1;
      reqSet = 6'b000001;
      tick();
      reset = 1'b0;
      reqSet = 6'b000000;
      ex("mid_rst_pending", SEL_PEND, 8'b0);
      ex("mid_rst_dir", SEL_DIR, 8'b00);
      ex("mid_rst_door", SEL_DOOR, 8'd0);
      ex("mid_rst_served", SEL_SERV, 8'b0);
      tick();
      ex("post_rst_dir", SEL_DIR, 8'b00);
      ex("post_rst_pending", SEL_PEND, 8'b0);

      ex("sb_drained", SEL_SBQ, 8'd0);
      tick();
      tick();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
